// File: rtl/coincidence_histogram_scanner_pkg.sv
// Shared CSR bit positions, scan FSM states and width helpers for the
// coincidence histogram scanner.
package coincidence_pkg;

    localparam int CSR_START_BIT    = 31;
    localparam int CSR_SETCOINC_BIT = 30;
    localparam int CSR_REALIGN_BIT  = 29;
    localparam int CSR_MUX_LSB      = 24;
    localparam int CSR_BUSY_BIT     = 31;

    typedef enum logic [3:0] {
        ST_IDLE         = 4'd0,
        ST_ARM          = 4'd1,
        ST_WAIT_BUSY_HI = 4'd2,
        ST_WAIT_BUSY_LO = 4'd3,
        ST_SET_ADDR     = 4'd4,
        ST_WAIT_RB      = 4'd5,
        ST_EVAL         = 4'd6,
        ST_DECIDE       = 4'd7,
        ST_COMMIT       = 4'd8,
        ST_REALIGN_GAP  = 4'd9,
        ST_REALIGN      = 4'd10,
        ST_DONE         = 4'd11
    } scan_state_t;

    function automatic int sum_width(input int cycles_per_acquisition);
        return $clog2(cycles_per_acquisition + 1);
    endfunction

    // A single-channel recorder still needs a one-bit mux field to index.
    function automatic int muxsel_width(input int channel_count);
        return (channel_count > 1) ? $clog2(channel_count) : 1;
    endfunction

endpackage

// File: rtl/coincidence_histogram_scanner_if.sv
// CSR bus between the scanner (master) and the coincidence recorder (slave).
interface coincidence_histogram_scanner_if;
    // sysCsrStrobe is a one-cycle command valid with no back-pressure; the
    // recorder must take the command that cycle. sysGPIO_OUT carries the command
    // only while the strobe is high and is zero otherwise. sysCsr is free-running status.
    logic [31:0] sysCsr;
    logic        sysCsrStrobe;
    logic [31:0] sysGPIO_OUT;

    modport master (input sysCsr, output sysCsrStrobe, output sysGPIO_OUT);
    modport slave  (output sysCsr, input sysCsrStrobe, input sysGPIO_OUT);
endinterface

// File: rtl/coincidence_histogram_scanner_edge_finder.sv
// Per-bin edge detection: threshold compare, rising-edge count and first
// edge address, including the wrap from the last bin back to bin 0.
module histogram_edge_finder #(
    parameter int SUM_WIDTH = 4,
    parameter int SCW       = 4,
    parameter int THRESHOLD = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 accept,
    input  logic                 first,
    input  logic                 last,
    input  logic [SUM_WIDTH-1:0] value,
    input  logic [SCW-1:0]       addr,
    output logic [1:0]           edge_count,
    output logic [SCW-1:0]       edge_address
);
    localparam logic [SUM_WIDTH-1:0] THR = SUM_WIDTH'(THRESHOLD);

    logic           h;
    logic           h0;
    logic           prev_h;
    logic           rise;
    logic           wrap;
    logic           hit;
    logic [SCW-1:0] hit_addr;

    // A rise into this bin and a wrap edge into bin 0 are mutually exclusive,
    // since the wrap needs the last bin low.
    always_comb begin
        h        = (value >= THR);
        rise     = !first && !prev_h && h;
        wrap     = last && !h && h0;
        hit      = accept && (rise || wrap);
        hit_addr = rise ? addr : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h0           <= 1'b0;
            prev_h       <= 1'b0;
            edge_count   <= 2'd0;
            edge_address <= '0;
        end else if (clear) begin
            h0           <= 1'b0;
            prev_h       <= 1'b0;
            edge_count   <= 2'd0;
            edge_address <= '0;
        end else if (accept) begin
            if (first) h0 <= h;
            prev_h <= h;
            if (hit) begin
                if (edge_count != 2'd3) edge_count <= edge_count + 2'd1;
                if (edge_count == 2'd0) edge_address <= hit_addr;
            end
        end
    end
endmodule

// File: rtl/coincidence_histogram_scanner.sv
// Scan controller: acquire, read back one channel's histogram, locate the
// single rising edge and program the coincidence sample count.
module coincidence_histogram_scanner
    import coincidence_pkg::*;
#(
    parameter int CHANNEL_COUNT               = 2,
    parameter int CYCLES_PER_ACQUISITION      = 15,
    parameter int SAMPLE_CLKS_PER_COINCIDENCE = 8,
    parameter int SAMPLE_COUNTER_WIDTH        = $clog2(2 * SAMPLE_CLKS_PER_COINCIDENCE),
    parameter int TIMEOUT_CYCLES              = 1000000,
    localparam int MUXSEL_WIDTH               = muxsel_width(CHANNEL_COUNT)
) (
    input  logic                            sysClk,
    input  logic                            sysReset,
    input  logic                            start,
    input  logic [MUXSEL_WIDTH-1:0]         channel,
    input  logic [SAMPLE_COUNTER_WIDTH-1:0] offset,
    input  logic                            autoRealign,
    coincidence_histogram_scanner_if.master csr,
    output logic                            busy,
    output logic                            done,
    output logic [SAMPLE_COUNTER_WIDTH-1:0] edgeAddress,
    output logic [1:0]                      edgeCount,
    output logic                            timeoutErr,
    output scan_state_t                     state_dbg
);
    localparam int SCW         = SAMPLE_COUNTER_WIDTH;
    localparam int SUM_WIDTH   = sum_width(CYCLES_PER_ACQUISITION);
    localparam int N_BINS      = 2 * SAMPLE_CLKS_PER_COINCIDENCE;
    localparam int THRESHOLD   = (CYCLES_PER_ACQUISITION + 1) / 2;
    localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    scan_state_t              state, state_next;
    logic [SCW-1:0]           addr;
    logic [MUXSEL_WIDTH-1:0]  ch_q;
    logic [SCW-1:0]           off_q;
    logic                     realign_q;
    logic [TIMER_WIDTH-1:0]   timer;
    logic                     match_seen;
    logic [SUM_WIDTH-1:0]     bin_value;
    logic                     timeout_fire;
    logic                     is_wait;
    logic                     match;
    logic                     last_bin;
    logic [SCW:0]             coinc_sum;
    logic [SCW-1:0]           coinc_value;

    always_comb begin
        is_wait  = (state == ST_WAIT_BUSY_HI) || (state == ST_WAIT_BUSY_LO) || (state == ST_WAIT_RB);
        match    = (csr.sysCsr[SUM_WIDTH +: SCW] == addr) &&
                   (csr.sysCsr[CSR_MUX_LSB +: MUXSEL_WIDTH] == ch_q);
        last_bin = (addr == SCW'(N_BINS - 1));
        coinc_sum   = {1'b0, edgeAddress} + {1'b0, off_q};
        coinc_value = SCW'((coinc_sum >= (SCW + 1)'(N_BINS)) ? coinc_sum - (SCW + 1)'(N_BINS) : coinc_sum);
    end

    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Meeting the wait condition wins over an expiry in the same cycle.
    always_comb begin
        state_next   = state;
        timeout_fire = 1'b0;
        case (state)
            ST_IDLE:         if (start) state_next = ST_ARM;
            ST_ARM:          state_next = ST_WAIT_BUSY_HI;
            ST_WAIT_BUSY_HI: if (csr.sysCsr[CSR_BUSY_BIT]) state_next = ST_WAIT_BUSY_LO;
                             else if (timer == '0) timeout_fire = 1'b1;
            ST_WAIT_BUSY_LO: if (!csr.sysCsr[CSR_BUSY_BIT]) state_next = ST_SET_ADDR;
                             else if (timer == '0) timeout_fire = 1'b1;
            ST_SET_ADDR:     state_next = ST_WAIT_RB;
            ST_WAIT_RB:      if (match && match_seen) state_next = ST_EVAL;
                             else if (timer == '0) timeout_fire = 1'b1;
            ST_EVAL:         state_next = last_bin ? ST_DECIDE : ST_SET_ADDR;
            ST_DECIDE:       state_next = (edgeCount == 2'd1) ? ST_COMMIT : ST_DONE;
            ST_COMMIT:       state_next = realign_q ? ST_REALIGN_GAP : ST_DONE;
            ST_REALIGN_GAP:  state_next = ST_REALIGN;
            ST_REALIGN:      state_next = ST_DONE;
            ST_DONE:         state_next = ST_IDLE;
            default:         state_next = ST_IDLE;
        endcase
        if (timeout_fire) state_next = ST_DONE;
    end

    always_comb begin
        csr.sysCsrStrobe = 1'b0;
        csr.sysGPIO_OUT  = 32'd0;
        busy             = (state != ST_IDLE) && (state != ST_DONE);
        done             = (state == ST_DONE);
        case (state)
            ST_ARM: begin
                csr.sysCsrStrobe               = 1'b1;
                csr.sysGPIO_OUT[CSR_START_BIT] = 1'b1;
            end
            ST_SET_ADDR: begin
                csr.sysCsrStrobe                            = 1'b1;
                csr.sysGPIO_OUT[SCW-1:0]                    = addr;
                csr.sysGPIO_OUT[CSR_MUX_LSB +: MUXSEL_WIDTH] = ch_q;
            end
            ST_COMMIT: begin
                csr.sysCsrStrobe                  = 1'b1;
                csr.sysGPIO_OUT[CSR_SETCOINC_BIT] = 1'b1;
                csr.sysGPIO_OUT[SCW-1:0]          = coinc_value;
            end
            ST_REALIGN: begin
                csr.sysCsrStrobe                 = 1'b1;
                csr.sysGPIO_OUT[CSR_REALIGN_BIT] = 1'b1;
            end
            default: ;
        endcase
    end

    // The timer reloads on every state change, so each wait state gets a full budget.
    always_ff @(posedge sysClk or posedge sysReset) begin
        if (sysReset) begin
            addr       <= '0;
            ch_q       <= '0;
            off_q      <= '0;
            realign_q  <= 1'b0;
            timer      <= '0;
            match_seen <= 1'b0;
            bin_value  <= '0;
            timeoutErr <= 1'b0;
        end else begin
            if (state_next != state)  timer <= TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
            else if (timer != '0)     timer <= timer - 1'b1;
            match_seen <= (state == ST_WAIT_RB) && match;
            if (state == ST_IDLE && start) begin
                ch_q       <= channel;
                off_q      <= offset;
                realign_q  <= autoRealign;
                timeoutErr <= 1'b0;
            end
            if (timeout_fire) timeoutErr <= 1'b1;
            if (state == ST_WAIT_BUSY_LO && !csr.sysCsr[CSR_BUSY_BIT]) addr <= '0;
            if (state == ST_WAIT_RB && match && match_seen) bin_value <= csr.sysCsr[SUM_WIDTH-1:0];
            if (state == ST_EVAL && !last_bin) addr <= addr + 1'b1;
        end
    end

    histogram_edge_finder #(
        .SUM_WIDTH (SUM_WIDTH),
        .SCW       (SCW),
        .THRESHOLD (THRESHOLD)
    ) u_edge_finder (
        .clk          (sysClk),
        .rst          (sysReset),
        .clear        (state == ST_IDLE && start),
        .accept       (state == ST_EVAL),
        .first        (addr == '0),
        .last         (last_bin),
        .value        (bin_value),
        .addr         (addr),
        .edge_count   (edgeCount),
        .edge_address (edgeAddress)
    );

    assign state_dbg = state;
endmodule
